// File: rtl/mic_channel_mixer.sv
// N-channel mic mixer: per-channel gain and L/R pan, sequential accumulate, saturate to a stereo pair.
// Optional peak meter output (peak_level) enabled by defining MIC_MIXER_PEAK_EN.
module mic_channel_mixer #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int GAIN_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_CH*DATA_W-1:0]   in_data,
  input  logic [NUM_CH*GAIN_W-1:0]   gain,
  input  logic [NUM_CH-1:0]          pan_right,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_left,
  output logic [DATA_W-1:0]          out_right,
  output logic                       overflow,
  input  logic                       clear_overflow
`ifdef MIC_MIXER_PEAK_EN
  ,
  output logic [DATA_W-2:0]          peak_level
`endif
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = DATA_W + GAIN_W + $clog2(NUM_CH) + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SAT   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Signed sample times unsigned Q1.x gain, floored back to sample scale.
  function automatic logic signed [ACC_W-1:0] scale_sample(input logic signed [DATA_W-1:0] s,
                                                          input logic [GAIN_W-1:0] g);
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] g_ext;
    logic signed [PROD_W-1:0] prod;
    s_ext = PROD_W'(s);
    g_ext = $signed(PROD_W'(g));
    prod  = (s_ext * g_ext) >>> (GAIN_W - 1);
    return ACC_W'(prod);
  endfunction

  function automatic logic [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    logic [DATA_W-1:0] r;
    if (a > SAT_MAX) begin
      r = SAT_MAX[DATA_W-1:0];
    end else if (a < SAT_MIN) begin
      r = SAT_MIN[DATA_W-1:0];
    end else begin
      r = a[DATA_W-1:0];
    end
    return r;
  endfunction

  function automatic logic clipped(input logic signed [ACC_W-1:0] a);
    return (a > SAT_MAX) || (a < SAT_MIN);
  endfunction

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_left_q, out_left_d;
  logic [DATA_W-1:0]        out_right_q, out_right_d;
  logic                     overflow_q, overflow_d;
  logic signed [ACC_W-1:0]  acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]  acc_r_q, acc_r_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DATA_W-1:0]        samp_q [NUM_CH];
  logic [DATA_W-1:0]        samp_d [NUM_CH];
  logic [GAIN_W-1:0]        gain_q [NUM_CH];
  logic [GAIN_W-1:0]        gain_d [NUM_CH];
  logic [NUM_CH-1:0]        pan_q, pan_d;

  logic signed [ACC_W-1:0]  cur_s;
  logic [DATA_W-1:0]        sat_l_s;
  logic [DATA_W-1:0]        sat_r_s;
  logic                     clip_s;

  // Per-cycle datapath: scaled term for the current channel and saturated views of the accumulators.
  always_comb begin
    cur_s   = scale_sample($signed(samp_q[idx_q]), gain_q[idx_q]);
    sat_l_s = saturate(acc_l_q);
    sat_r_s = saturate(acc_r_q);
    clip_s  = clipped(acc_l_q) || clipped(acc_r_q);
  end

  // Next-state logic for the frame FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    idx_d       = idx_q;
    samp_d      = samp_q;
    gain_d      = gain_q;
    pan_d       = pan_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          for (int k = 0; k < NUM_CH; k++) begin
            samp_d[k] = in_data[k*DATA_W +: DATA_W];
            gain_d[k] = gain[k*GAIN_W +: GAIN_W];
          end
          pan_d   = pan_right;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (pan_q[idx_q]) begin
          acc_r_d = acc_r_q + cur_s;
        end else begin
          acc_l_d = acc_l_q + cur_s;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_SAT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SAT: begin
        out_left_d  = sat_l_s;
        out_right_d = sat_r_s;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  // Sticky overflow: a new clip in SAT outranks a same-cycle clear.
  always_comb begin
    if ((state_q == S_SAT) && clip_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      overflow_q  <= 1'b0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      idx_q       <= '0;
      pan_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        samp_q[k] <= '0;
        gain_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      overflow_q  <= overflow_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      idx_q       <= idx_d;
      pan_q       <= pan_d;
      samp_q      <= samp_d;
      gain_q      <= gain_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign overflow  = overflow_q;

`ifdef MIC_MIXER_PEAK_EN
  // Magnitude of a saturated sample; the most negative value folds onto the positive maximum.
  function automatic logic [DATA_W-2:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    logic [DATA_W-2:0] r;
    neg = -x;
    if (!x[DATA_W-1]) begin
      r = x[DATA_W-2:0];
    end else if (x[DATA_W-2:0] == '0) begin
      r = '1;
    end else begin
      r = neg[DATA_W-2:0];
    end
    return r;
  endfunction

  logic [DATA_W-2:0] peak_q, peak_d;
  logic [DATA_W-2:0] abs_l_s, abs_r_s;

  // Peak tracker: update in SAT outranks a same-cycle clear.
  always_comb begin
    abs_l_s = abs_sat(sat_l_s);
    abs_r_s = abs_sat(sat_r_s);
    if (state_q == S_SAT) begin
      peak_d = (abs_l_s > peak_q) ? abs_l_s : peak_q;
      peak_d = (abs_r_s > peak_d) ? abs_r_s : peak_d;
    end else if (clear_overflow) begin
      peak_d = '0;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_level = peak_q;
`endif

endmodule

// File: tb/tb_mic_channel_mixer.sv
// Scoreboard bench for mic_channel_mixer (8 ch, 32-bit samples, Q1.15 gain); MIC_MIXER_PEAK_EN adds peak checks.
module tb_mic_channel_mixer;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int GW  = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [NCH*DW-1:0] in_data;
  logic [NCH*GW-1:0] gain;
  logic [NCH-1:0]    pan_right;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_left;
  logic [DW-1:0]     out_right;
  logic              overflow;
  logic              clear_overflow;
`ifdef MIC_MIXER_PEAK_EN
  logic [DW-2:0]     peak_level;
`endif

  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;
  int   last_accept = 0;
  exp_t sb_q[$];

  mic_channel_mixer #(.NUM_CH(NCH), .DATA_W(DW), .GAIN_W(GW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .gain(gain), .pan_right(pan_right),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right),
    .overflow(overflow), .clear_overflow(clear_overflow)
`ifdef MIC_MIXER_PEAK_EN
    , .peak_level(peak_level)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] clamp(input longint v);
    logic [DW-1:0] r;
    if (v > MAXV) r = 32'h7FFF_FFFF;
    else if (v < MINV) r = 32'h8000_0000;
    else r = v[DW-1:0];
    return r;
  endfunction

  function automatic exp_t model(input logic [NCH*DW-1:0] d, input logic [NCH*GW-1:0] g,
                                 input logic [NCH-1:0] p);
    exp_t e;
    longint al, ar, prod;
    logic [DW-1:0] s;
    logic [GW-1:0] gg;
    al = 0;
    ar = 0;
    for (int k = 0; k < NCH; k++) begin
      s    = d[k*DW +: DW];
      gg   = g[k*GW +: GW];
      prod = longint'($signed(s)) * longint'(gg);
      prod = prod >>> (GW - 1);
      if (p[k]) ar += prod;
      else al += prod;
    end
    e.l = clamp(al);
    e.r = clamp(ar);
    return e;
  endfunction

  function automatic logic [NCH*GW-1:0] all_gain(input logic [GW-1:0] g);
    logic [NCH*GW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*GW +: GW] = g;
    return r;
  endfunction

  // Scoreboard: every output handshake is popped and compared.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fails++;
        $display("FAIL sb_unexpected: output L=%h R=%h with empty scoreboard", out_left, out_right);
      end else begin
        e = sb_q.pop_front();
        if (out_left !== e.l) begin
          n_fails++;
          $display("FAIL sb_left: got %h expected %h", out_left, e.l);
        end
        n_checks++;
        if (out_right !== e.r) begin
          n_fails++;
          $display("FAIL sb_right: got %h expected %h", out_right, e.r);
        end
      end
    end
  end

  task automatic send_frame(input logic [NCH*DW-1:0] d, input logic [NCH*GW-1:0] g,
                            input logic [NCH-1:0] p, output bit ok);
    bit acc;
    acc = 1'b0;
    in_data = d;
    gain = g;
    pan_right = p;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      if (in_ready) begin
        acc = 1'b1;
        last_accept = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (acc) sb_q.push_back(model(d, g, p));
    ok = acc;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0 && in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100) begin
      n_fails++;
      $display("FAIL reset_ctrl: rdy/vld/ovf got %b expected 100", {in_ready, out_valid, overflow});
    end
    n_checks++;
    if ({out_left, out_right} !== 64'd0) begin
      n_fails++;
      $display("FAIL reset_data: got %h %h expected 0 0", out_left, out_right);
    end
`ifdef MIC_MIXER_PEAK_EN
    n_checks++;
    if (peak_level !== 31'd0) begin
      n_fails++;
      $display("FAIL reset_peak: got %h expected 0", peak_level);
    end
`endif
  endtask

  task automatic test_unity;
    logic [NCH*DW-1:0] d;
    bit ok;
    bit early;
    d = '0;
    d[0 +: DW] = 32'd100;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL unity_accept: got no accept expected accept"); end
    early = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (out_valid) early = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (early) begin n_fails++; $display("FAIL unity_latency_early: out_valid before T+10"); end
    n_checks++;
    if (out_valid !== 1'b1) begin n_fails++; $display("FAIL unity_latency: out_valid got %b expected 1 at T+10", out_valid); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fails++; $display("FAIL unity_ovf: got %b expected 0", overflow); end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fails++; $display("FAIL unity_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_floor;
    logic [NCH*DW-1:0] d;
    logic [NCH*GW-1:0] g;
    bit ok;
    d = '0;
    g = '0;
    d[1*DW +: DW] = -32'sd7;
    g[1*GW +: GW] = 16'h4000;
    send_frame(d, g, 8'b0000_0010, ok);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL floor_drain: got timeout expected completion"); end
  endtask

  task automatic test_saturation;
    logic [NCH*DW-1:0] d;
    bit ok;
    d = '0;
    for (int k = 0; k < 4; k++) d[k*DW +: DW] = 32'h7000_0000;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    drain(ok);
    n_checks++;
    if (overflow !== 1'b1) begin n_fails++; $display("FAIL sat_ovf_set: got %b expected 1", overflow); end
`ifdef MIC_MIXER_PEAK_EN
    n_checks++;
    if (peak_level !== 31'h7FFF_FFFF) begin n_fails++; $display("FAIL sat_peak: got %h expected 7fffffff", peak_level); end
`endif
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fails++; $display("FAIL sat_ovf_clear: got %b expected 0", overflow); end
    // Max gain on most-negative samples, all right; clear pulsed in the SAT cycle.
    for (int k = 0; k < NCH; k++) d[k*DW +: DW] = 32'h8000_0000;
    send_frame(d, all_gain(16'hFFFF), 8'hFF, ok);
    repeat (8) begin @(posedge clk); #1; end
    n_checks++;
    if (overflow !== 1'b0) begin n_fails++; $display("FAIL negsat_pre: overflow got %b expected 0", overflow); end
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    n_checks++;
    if ({out_valid, overflow} !== 2'b11) begin
      n_fails++;
      $display("FAIL negsat_set_wins: vld/ovf got %b expected 11", {out_valid, overflow});
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL negsat_drain: got timeout expected completion"); end
  endtask

  task automatic test_backpressure;
    logic [NCH*DW-1:0] da, db;
    logic [NCH*GW-1:0] ga, gb;
    exp_t ea;
    bit ok;
    da = '0; db = '0; ga = '0; gb = '0;
    da[0*DW +: DW] = 32'd1000;   ga[0*GW +: GW] = 16'h8000;
    da[1*DW +: DW] = -32'sd300;  ga[1*GW +: GW] = 16'h8000;
    db[3*DW +: DW] = 32'd12345;  gb[3*GW +: GW] = 16'h2000;
    ea = model(da, ga, 8'b0000_0010);
    out_ready = 1'b0;
    send_frame(da, ga, 8'b0000_0010, ok);
    repeat (9) begin @(posedge clk); #1; end
    in_data = db; gain = gb; pan_right = 8'h00; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
        n_fails++;
        $display("FAIL bp_ctrl[%0d]: vld/rdy got %b expected 10", i, {out_valid, in_ready});
      end
      n_checks++;
      if ({out_left, out_right} !== {ea.l, ea.r}) begin
        n_fails++;
        $display("FAIL bp_hold[%0d]: got %h %h expected %h %h", i, out_left, out_right, ea.l, ea.r);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_fails++;
      $display("FAIL bp_release: rdy/vld got %b expected 10", {in_ready, out_valid});
    end
    sb_q.push_back(model(db, gb, 8'h00));
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fails++; $display("FAIL bp_second_accept: in_ready got %b expected 0", in_ready); end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL bp_drain: got timeout expected completion"); end
  endtask

  task automatic test_snapshot;
    logic [NCH*DW-1:0] d;
    bit ok;
    d = '0;
    d[2*DW +: DW] = 32'd50;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    gain = '0;
    pan_right = 8'hFF;
    in_data = {NCH{32'h1234_5678}};
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL snap_drain: got timeout expected completion"); end
  endtask

  task automatic test_back_to_back;
    logic [NCH*DW-1:0] d;
    logic [NCH*GW-1:0] g;
    int acc_at [3];
    bit ok;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NCH; k++) begin
        d[k*DW +: DW] = (f == 1) ? $urandom : 32'($urandom_range(0, 65535)) - 32'd32768;
        g[k*GW +: GW] = 16'($urandom);
      end
      send_frame(d, g, 8'($urandom), ok);
      acc_at[f] = last_accept;
    end
    n_checks++;
    if ((acc_at[1] - acc_at[0]) != 11 || (acc_at[2] - acc_at[1]) != 11) begin
      n_fails++;
      $display("FAIL b2b_rate: spacing got %0d,%0d expected 11,11", acc_at[1] - acc_at[0], acc_at[2] - acc_at[1]);
    end
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL b2b_drain: got timeout expected completion"); end
  endtask

  task automatic test_reset_mid;
    logic [NCH*DW-1:0] d;
    bit ok;
    bit stray;
    d = '0;
    for (int k = 0; k < 4; k++) d[k*DW +: DW] = 32'h7000_0000;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    drain(ok);
    d = '0;
    d[0 +: DW] = 32'd100;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    n_checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100) begin
      n_fails++;
      $display("FAIL rstmid_ctrl: rdy/vld/ovf got %b expected 100", {in_ready, out_valid, overflow});
    end
    n_checks++;
    if ({out_left, out_right} !== 64'd0) begin
      n_fails++;
      $display("FAIL rstmid_data: got %h %h expected 0 0", out_left, out_right);
    end
`ifdef MIC_MIXER_PEAK_EN
    n_checks++;
    if (peak_level !== 31'd0) begin n_fails++; $display("FAIL rstmid_peak: got %h expected 0", peak_level); end
`endif
    reset = 1'b0;
    stray = 1'b0;
    repeat (15) begin
      if (out_valid) stray = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (stray) begin n_fails++; $display("FAIL rstmid_abort: got out_valid expected aborted frame"); end
    d[0 +: DW] = 32'd777;
    send_frame(d, all_gain(16'h8000), 8'h00, ok);
    drain(ok);
    n_checks++;
    if (!ok) begin n_fails++; $display("FAIL rstmid_recover: got timeout expected completion"); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    gain = '0;
    pan_right = '0;
    out_ready = 1'b1;
    clear_overflow = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_unity();
    test_floor();
    test_saturation();
    test_backpressure();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fails++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
